// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared lamp codes, phase encoding and lamp decode for intersection control blocks.
package intersection_phase_scheduler_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    typedef enum logic [2:0] {
        HWY_GREEN  = 3'd0,
        HWY_YELLOW = 3'd1,
        ALLRED_A   = 3'd2,
        CTY_GREEN  = 3'd3,
        CTY_YELLOW = 3'd4,
        PED_WALK   = 3'd5,
        ALLRED_B   = 3'd6
    } phase_e;

    typedef struct packed {
        logic [2:0] highway;
        logic [2:0] country_road;
        logic       ped_walk;
    } lamps_t;

    // Lamp pattern for a phase; unknown codes show all-red with walk off.
    function automatic lamps_t decode_lamps(input phase_e ph);
        lamps_t l;
        l.highway      = LIGHT_RED;
        l.country_road = LIGHT_RED;
        l.ped_walk     = 1'b0;
        case (ph)
            HWY_GREEN:  l.highway      = LIGHT_GREEN;
            HWY_YELLOW: l.highway      = LIGHT_YELLOW;
            CTY_GREEN:  l.country_road = LIGHT_GREEN;
            CTY_YELLOW: l.country_road = LIGHT_YELLOW;
            PED_WALK:   l.ped_walk     = 1'b1;
            default:    ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/intersection_phase_scheduler_if.sv
// Sensor inputs and lamp/monitor outputs of the intersection scheduler.
interface intersection_phase_scheduler_if;

    logic       country_req;
    logic       ped_req;
    logic [2:0] highway;
    logic [2:0] country_road;
    logic       ped_walk;
    logic       ped_pending;
    logic [2:0] phase;

    modport master (
        output country_req, ped_req,
        input  highway, country_road, ped_walk, ped_pending, phase
    );

    modport slave (
        input  country_req, ped_req,
        output highway, country_road, ped_walk, ped_pending, phase
    );

endinterface

// File: rtl/intersection_phase_scheduler_phase_timer.sv
// Elapsed-cycle counter: zeroed on reset or phase change, otherwise counts up and saturates.
module intersection_phase_scheduler_phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             restart,
    output logic [CNT_W-1:0] elapsed
);

    logic [CNT_W-1:0] elapsed_q;
    logic [CNT_W-1:0] elapsed_d;

    always_comb begin
        elapsed_d = elapsed_q;
        if (restart) begin
            elapsed_d = '0;
        end else if (!(&elapsed_q)) begin
            elapsed_d = elapsed_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            elapsed_q <= '0;
        end else begin
            elapsed_q <= elapsed_d;
        end
    end

    assign elapsed = elapsed_q;

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Highway/country intersection sequencer with a latched pedestrian walk phase.
module intersection_phase_scheduler
    import intersection_phase_scheduler_pkg::*;
#(
    parameter int unsigned GREEN_MIN = 4,
    parameter int unsigned GREEN_MAX = 10,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned PED_T     = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                          clk,
    input  logic                          clear,
    intersection_phase_scheduler_if.slave bus
);

    // Last elapsed value of each interval; the exit decision is taken at that edge.
    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ARED_LAST = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] PED_LAST  = CNT_W'(PED_T - 1);

    phase_e           state_q;
    phase_e           state_d;
    logic             ped_pending_q;
    logic             ped_pending_d;
    lamps_t           lamps_q;
    lamps_t           lamps_d;
    logic             state_change;
    logic [CNT_W-1:0] elapsed;

    intersection_phase_scheduler_phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk     (clk),
        .clear   (clear),
        .restart (state_change),
        .elapsed (elapsed)
    );

    always_comb begin
        state_d       = state_q;
        ped_pending_d = ped_pending_q | bus.ped_req;
        lamps_d       = decode_lamps(state_q);
        state_change  = 1'b0;

        case (state_q)
            HWY_GREEN: begin
                if (elapsed >= GMIN_LAST && (bus.country_req || ped_pending_q)) begin
                    state_d = HWY_YELLOW;
                end
            end
            HWY_YELLOW: begin
                if (elapsed == YEL_LAST) state_d = ALLRED_A;
            end
            ALLRED_A: begin
                if (elapsed == ARED_LAST) state_d = ped_pending_q ? PED_WALK : CTY_GREEN;
            end
            CTY_GREEN: begin
                if ((elapsed >= GMIN_LAST && !bus.country_req) || elapsed == GMAX_LAST) begin
                    state_d = CTY_YELLOW;
                end
            end
            CTY_YELLOW: begin
                if (elapsed == YEL_LAST) state_d = ALLRED_B;
            end
            PED_WALK: begin
                if (elapsed == PED_LAST) state_d = ALLRED_B;
            end
            ALLRED_B: begin
                if (elapsed == ARED_LAST) state_d = HWY_GREEN;
            end
            default: state_d = HWY_GREEN;
        endcase

        // Entering the walk serves the request, even one arriving on that same edge.
        if (state_d == PED_WALK && state_q != PED_WALK) begin
            ped_pending_d = 1'b0;
        end

        state_change = (state_d != state_q);
        lamps_d      = decode_lamps(state_d);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q       <= HWY_GREEN;
            ped_pending_q <= 1'b0;
            lamps_q       <= decode_lamps(HWY_GREEN);
        end else begin
            state_q       <= state_d;
            ped_pending_q <= ped_pending_d;
            lamps_q       <= lamps_d;
        end
    end

    assign bus.highway      = lamps_q.highway;
    assign bus.country_road = lamps_q.country_road;
    assign bus.ped_walk     = lamps_q.ped_walk;
    assign bus.ped_pending  = ped_pending_q;
    assign bus.phase        = 3'(state_q);

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench for intersection_phase_scheduler: cycle model plus directed phase-length checks.
module tb_intersection_phase_scheduler;

    localparam int GMIN = 4;
    localparam int GMAX = 10;
    localparam int YEL  = 2;
    localparam int ARED = 1;
    localparam int PEDT = 3;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YLW = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef struct {
        logic [2:0] hw;
        logic [2:0] cr;
        logic       walk;
        logic       pend;
        logic [2:0] ph;
    } exp_t;

    logic clk;
    logic clear;
    intersection_phase_scheduler_if bus();

    intersection_phase_scheduler dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb_q[$];

    logic drv_creq = 1'b0;
    logic drv_pr   = 1'b0;
    logic drv_clr  = 1'b0;

    int m_state = 0;
    int m_el    = 0;
    bit m_pend  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the reference model by one edge and return the lamps it expects afterwards.
    task automatic model_step(output exp_t e);
        int ns;
        ns = m_state;
        case (m_state)
            0: if (m_el >= GMIN - 1 && (drv_creq || m_pend)) ns = 1;
            1: if (m_el == YEL - 1) ns = 2;
            2: if (m_el == ARED - 1) ns = m_pend ? 5 : 3;
            3: if ((m_el >= GMIN - 1 && !drv_creq) || m_el == GMAX - 1) ns = 4;
            4: if (m_el == YEL - 1) ns = 6;
            5: if (m_el == PEDT - 1) ns = 6;
            6: if (m_el == ARED - 1) ns = 0;
            default: ns = 0;
        endcase
        if (drv_clr) begin
            ns     = 0;
            m_el   = 0;
            m_pend = 1'b0;
        end else begin
            if (ns == 5 && m_state != 5) m_pend = 1'b0;
            else                         m_pend = m_pend | drv_pr;
            if (ns != m_state) m_el = 0;
            else if (m_el < 255) m_el = m_el + 1;
        end
        m_state = ns;
        e.hw   = (ns == 0) ? GRN : (ns == 1) ? YLW : RED;
        e.cr   = (ns == 3) ? GRN : (ns == 4) ? YLW : RED;
        e.walk = (ns == 5);
        e.pend = m_pend;
        e.ph   = 3'(ns);
    endtask

    // Drive the current inputs across one rising edge, then score the DUT at the falling edge.
    task automatic cycle();
        exp_t e;
        model_step(e);
        sb_q.push_back(e);
        bus.country_req = drv_creq;
        bus.ped_req     = drv_pr;
        clear           = drv_clr;
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        check_eq("highway",      32'(bus.highway),      32'(e.hw));
        check_eq("country_road", 32'(bus.country_road), 32'(e.cr));
        check_eq("ped_walk",     32'(bus.ped_walk),     32'(e.walk));
        check_eq("ped_pending",  32'(bus.ped_pending),  32'(e.pend));
        check_eq("phase",        32'(bus.phase),        32'(e.ph));
        check_eq("safety", 32'(bus.highway != RED && bus.country_road != RED), 32'(0));
    endtask

    task automatic do_clear();
        drv_clr = 1'b1;
        cycle();
        drv_clr = 1'b0;
    endtask

    // Confirm the DUT is in phase ph and stays there for len observed cycles (bounded).
    task automatic expect_run(input string tag, input int ph, input int len);
        int n;
        check_eq({tag, "_ph"}, 32'(bus.phase), 32'(ph));
        n = 1;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (bus.phase != 3'(ph)) break;
            n++;
        end
        check_eq({tag, "_len"}, 32'(n), 32'(len));
    endtask

    initial begin
        bus.country_req = 1'b0;
        bus.ped_req     = 1'b0;
        clear           = 1'b1;

        // Idle: highway holds green indefinitely.
        do_clear();
        check_eq("rst_hw",   32'(bus.highway),      32'(GRN));
        check_eq("rst_cr",   32'(bus.country_road), 32'(RED));
        check_eq("rst_pend", 32'(bus.ped_pending),  32'(0));
        for (int i = 0; i < 20; i++) begin
            cycle();
            check_eq("idle_ph", 32'(bus.phase), 32'(0));
        end

        // Country request held: max-green cap and full loop.
        drv_creq = 1'b1;
        do_clear();
        expect_run("s2_hg",  0, GMIN);
        expect_run("s2_hy",  1, YEL);
        expect_run("s2_ara", 2, ARED);
        expect_run("s2_cg",  3, GMAX);
        expect_run("s2_cy",  4, YEL);
        expect_run("s2_arb", 6, ARED);
        expect_run("s2_hg2", 0, GMIN);
        expect_run("s2_hy2", 1, YEL);

        // Country request drops two cycles into country green: green totals GREEN_MIN.
        do_clear();
        expect_run("s3_hg",  0, GMIN);
        expect_run("s3_hy",  1, YEL);
        expect_run("s3_ara", 2, ARED);
        cycle();
        cycle();
        drv_creq = 1'b0;
        expect_run("s3_cg_rest", 3, GMIN - 2);
        expect_run("s3_cy",  4, YEL);
        expect_run("s3_arb", 6, ARED);
        check_eq("s3_back", 32'(bus.phase), 32'(0));

        // Single-cycle pedestrian pulse at elapsed=1 of highway green.
        do_clear();
        cycle();
        drv_pr = 1'b1;
        cycle();
        drv_pr = 1'b0;
        check_eq("s4_pend", 32'(bus.ped_pending), 32'(1));
        expect_run("s4_hg",  0, GMIN - 2);
        expect_run("s4_hy",  1, YEL);
        expect_run("s4_ara", 2, ARED);
        check_eq("s4_pend_clr", 32'(bus.ped_pending), 32'(0));
        check_eq("s4_walk_lamp", 32'(bus.ped_walk), 32'(1));
        expect_run("s4_walk", 5, PEDT);
        expect_run("s4_arb",  6, ARED);
        check_eq("s4_back", 32'(bus.phase), 32'(0));

        // Both requests: pedestrian first; a press during the walk re-arms the latch.
        drv_creq = 1'b1;
        do_clear();
        drv_pr = 1'b1;
        cycle();
        drv_pr = 1'b0;
        repeat (6) cycle();
        check_eq("s5_walk", 32'(bus.phase), 32'(5));
        drv_pr = 1'b1;
        cycle();
        drv_pr = 1'b0;
        check_eq("s5_rearm", 32'(bus.ped_pending), 32'(1));
        repeat (30) cycle();

        // Clear mid country green with a pending pedestrian request.
        do_clear();
        repeat (7) cycle();
        check_eq("s6_cg", 32'(bus.phase), 32'(3));
        drv_pr = 1'b1;
        cycle();
        drv_pr = 1'b0;
        cycle();
        check_eq("s6_pend", 32'(bus.ped_pending), 32'(1));
        drv_clr = 1'b1;
        cycle();
        drv_clr = 1'b0;
        check_eq("s6_hw",   32'(bus.highway),      32'(GRN));
        check_eq("s6_cr",   32'(bus.country_road), 32'(RED));
        check_eq("s6_pend_clr", 32'(bus.ped_pending), 32'(0));
        check_eq("s6_ph",   32'(bus.phase),        32'(0));
        drv_creq = 1'b0;
        repeat (5) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
- Sequences the two-road intersection, highway vs. country road, and adds a latched pedestrian crossing phase.
- Arbitrates highway right-of-way against country-road sensor requests and pedestrian button requests.
- Enforces minimum green, maximum country green, yellow and all-red clearance intervals.
- Drives the same 3-bit per-road light codes as the existing traffic_signal outputs. Sits between the road/pedestrian sensors and the lamp drivers.

Parameters:
- GREEN_MIN, 4: minimum cycles of any road green before it may be preempted.
- GREEN_MAX, 10: maximum cycles of country green.
- YELLOW_T, 2: yellow interval in cycles.
- ALLRED_T, 1: all-red clearance in cycles.
- PED_T, 3: pedestrian walk interval in cycles.
- CNT_W, 8: width of the elapsed-cycle counter.
- Legality: all durations are >=1 and < 2**CNT_W, and GREEN_MAX >= GREEN_MIN.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  synchronous active-high reset.
- country_req  in  1  country-road vehicle sensor, level.
- ped_req  in  1  pedestrian button; a pulse of one or more cycles is latched.
- highway  out  3  highway light code.
- country_road  out  3  country-road light code.
- ped_walk  out  1  walk lamp.
- ped_pending  out  1  latched pedestrian request not yet served.
- phase  out  3  current state code, for debug and monitoring.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high on clear, sampled at the clk rising edge.
- Light codes: RED=3'b100, YELLOW=3'b010, GREEN=3'b001.
- Registers: state, an elapsed counter (elapsed) and ped_pending.
- Outputs: pure decode of the state register; no combinational path from inputs.
- elapsed clears to 0 on every state change. Otherwise it increments and saturates at all-ones.
- Reset values (clear=1 at an edge): state=HWY_GREEN, elapsed=0, ped_pending=0, highway=GREEN, country_road=RED, ped_walk=0, phase=0.
- clear overrides all other activity in every state, mid-phase included, and discards any pending pedestrian request.
- States, codes and transitions (each is evaluated at the edge using the current elapsed value):
  - HWY_GREEN (0), highway=GREEN, country=RED: advance to HWY_YELLOW when elapsed >= GREEN_MIN-1 and (country_req or ped_pending). Otherwise stay, indefinitely.
  - HWY_YELLOW (1), highway=YELLOW, country=RED: advance to ALLRED_A when elapsed == YELLOW_T-1.
  - ALLRED_A (2), both RED: when elapsed == ALLRED_T-1, go to PED_WALK if ped_pending, else CTY_GREEN. Pedestrian has priority over country.
  - CTY_GREEN (3), highway=RED, country=GREEN: advance to CTY_YELLOW when (elapsed >= GREEN_MIN-1 and !country_req) or elapsed == GREEN_MAX-1.
  - CTY_YELLOW (4), highway=RED, country=YELLOW: advance to ALLRED_B when elapsed == YELLOW_T-1.
  - PED_WALK (5), both RED, ped_walk=1: advance to ALLRED_B when elapsed == PED_T-1.
  - ALLRED_B (6), both RED: go to HWY_GREEN when elapsed == ALLRED_T-1.
- Phase durations: fixed-length states last exactly their parameter in cycles. HWY_GREEN always lasts at least GREEN_MIN cycles after any entry, including after reset.
- ALLRED_A with no pending request: if country_req dropped while in yellow, CTY_GREEN is still entered. It then exits after GREEN_MIN cycles.
- ped_pending set and clear:
  - Set at the edge after ped_req=1.
  - Cleared at the edge where state enters PED_WALK.
  - If ped_req=1 on that same edge, the clear wins; the request is served by the current walk.
  - ped_req asserted while in PED_WALK or later sets ped_pending again, to be served on the next cycle round.
- Illegal state codes (7) recover to HWY_GREEN at the next edge.
- Safety invariant: highway and country_road are never both non-RED in the same cycle.

Decomposition:
- Shared package holds the light-code constants (RED, YELLOW, GREEN) and the state enumeration with its 3-bit codes. traffic_signal and future intersection blocks reuse both.
- Natural sub-module: phase_timer, the elapsed counter with clear-on-state-change and saturation. It takes CNT_W as its parameter.
- The FSM and request latch stay in the top module.

Test Plan:
- Idle: clear for 1 cycle, then 20 cycles with no requests -> highway=001, country_road=100 and ped_walk=0 every cycle, with phase=0 throughout.
- country_req held at 1 from reset release -> highway GREEN 4 cycles, YELLOW 2, all-red 1, country GREEN 10 cycles (max cap), YELLOW 2, all-red 1, highway GREEN 4, and the loop repeats.
- country_req drops after 2 cycles into CTY_GREEN -> country GREEN exactly 4 cycles (GREEN_MIN), then YELLOW 2, all-red 1, highway GREEN.
- 1-cycle ped_req pulse at elapsed=1 of HWY_GREEN -> ped_pending=1 on the next cycle. Highway then goes YELLOW after 4 green cycles, then all-red 1, then PED_WALK 3 cycles with ped_walk=1 and both roads 100. ped_pending falls on PED_WALK entry, followed by all-red 1 and highway GREEN.
- country_req and ped_req both asserted -> pedestrian phase is served first, then highway GREEN 4 cycles, then country green. A ped_req during PED_WALK re-sets ped_pending.
- clear asserted at elapsed=2 of CTY_GREEN with ped_pending=1 -> next cycle highway=001, country_road=100, ped_pending=0, phase=0. Throughout all scenarios, assert that both roads are never simultaneously non-RED.
